axi_slave_mem_arb: RTL and testbench
====================================

// Module: axi_slave_mem_arb
// PURPOSE
//  - Shares one single-ported memory command port between axi_slave's write packet channel and its read packet channel.
//  - Round-robin arbitration with grant lock; credit-limited read issue; in-order read-return queue back to axi_slave rdret channel.
//  - Sits between axi_slave packet ports and the memory/backing-store model.
// PARAMETERS
//  AW               32      address width
//  DW               32      data width
//  SW               DW/8    write strobe width
//  MAX_OUTSTANDING  4       max reads issued but not yet delivered on rdret (>=1); also return-queue depth
//  WR_BURST_MAX     4       max consecutive write grants while a read waits (AXI_SLV_ARB_WR_BURST_EN only; >=1)
// PORTS
//  i_axi_aclk          in   1      clock
//  i_axi_aresetn       in   1      async reset, active low
//  i_wr_pkt_valid      in   1      write request valid
//  o_wr_pkt_ready      out  1      write request accepted
//  i_wr_pkt_addr       in   AW     write address
//  i_wr_pkt_data       in   DW     write data
//  i_wr_pkt_strb       in   SW     write strobes
//  i_rd_pkt_valid      in   1      read request valid
//  o_rd_pkt_ready      out  1      read request accepted
//  i_rd_pkt_addr       in   AW     read address
//  o_rdret_pkt_valid   out  1      read data to slave valid
//  i_rdret_pkt_ready   in   1      slave accepts read data
//  o_rdret_pkt_data    out  DW     read data to slave
//  o_mem_valid         out  1      memory command valid
//  i_mem_ready         in   1      memory accepts command
//  o_mem_we            out  1      1=write, 0=read
//  o_mem_addr          out  AW     command address
//  o_mem_wdata         out  DW     write data (0 on reads)
//  o_mem_wstrb         out  SW     write strobes (0 on reads)
//  i_mem_rvalid        in   1      read data return, no backpressure, in issue order
//  i_mem_rdata         in   DW     returned read data
//  o_rd_outstanding    out  CW     credits in use, CW=$clog2(MAX_OUTSTANDING+1)
//  o_err               out  1      sticky: i_mem_rvalid with no read outstanding, or queue full
// BEHAVIOUR
//  - Reset values: o_mem_valid=0, o_wr/rd_pkt_ready=0, o_rdret_pkt_valid=0, o_rd_outstanding=0, o_err=0.
//  - Reset values: credits=MAX_OUTSTANDING, last-grant=READ so first contested grant is WRITE, lock=0, queue empty.
//  - Eligibility: wr_elig=i_wr_pkt_valid; rd_elig=i_rd_pkt_valid && credits!=0.
//  - Grant (combinational, 0-cycle): if lock held, keep locked requester.
//    - Else if one eligible, grant it; if both, grant opposite of last-grant.
//  - o_mem_* driven from granted request; o_mem_valid=granted requester's valid.
//  - o_wr_pkt_ready=gnt_wr&&i_mem_ready; o_rd_pkt_ready=gnt_rd&&i_mem_ready.
//  - Lock: set when o_mem_valid&&!i_mem_ready; cleared on handshake.
//    - Payload/grant never change while locked (AXI stability).
//  - last-grant updates on each mem handshake.
//  - Credits: -1 on read handshake; +1 on rdret handshake; both same cycle -> unchanged.
//    - o_rd_outstanding=MAX_OUTSTANDING-credits.
//  - Return queue: FIFO depth MAX_OUTSTANDING, push on i_mem_rvalid.
//    - o_rdret_pkt_valid=!empty; registered, 1-cycle latency rvalid->rdret valid.
//    - Push and pop same cycle allowed, including at full.
//  - Credits guarantee no overflow; push when full or when credits==MAX sets o_err, data dropped.
//    - o_err clears only on reset.
//  - Reset mid-operation: all state cleared asynchronously; in-flight reads discarded; memory must be reset together.
// CONFIGURATION
//  - AXI_SLV_ARB_WR_BURST_EN defined: when both eligible, write keeps grant for up to WR_BURST_MAX consecutive handshakes, then yields one grant to read.
//    - Burst counter resets when read granted or write not valid.
//  - AXI_SLV_ARB_WR_BURST_EN undefined: strict alternation as above; WR_BURST_MAX ignored.
// STRUCTURE
//  - Package axi_slave_arb_pkg: typedef enum logic [1:0] {GNT_NONE,GNT_WR,GNT_RD} arb_gnt_t.
//    - Package also holds the cmd struct {we,addr,wdata,wstrb} parameterised via localparams.
//  - Sub-module: axi_slave_arb_retq (sync FIFO, depth MAX_OUTSTANDING, width DW, count output).
//  - Arbiter/credit logic in top.
// TESTING
//  1 Writes only, mem ready=1: addr 0x100,0x104,0x108 -> three back-to-back o_mem_we=1 handshakes, o_wr_pkt_ready=1 each cycle.
//  2 Both valid continuously, macro off -> grant sequence W,R,W,R,... starting W after reset.
//  3 MAX_OUTSTANDING=4, no i_mem_rvalid, 6 reads queued -> 4 issued, o_rd_pkt_ready=0 after, o_rd_outstanding=4, writes still granted.
//  4 Read granted, i_mem_ready=0 for 3 cycles, write arrives -> grant stays RD, o_mem_addr stable, write granted next cycle after handshake.
//  5 Return 0xA0..0xA3 with i_rdret_pkt_ready=0 -> all queued, o_err=0; ready=1 -> delivered in order, credits back to 4.
//    - Issue+return same cycle keeps count.
//  6 Macro on, WR_BURST_MAX=4, both valid -> W,W,W,W,R,W,W,W,W,R; rvalid with 0 outstanding -> o_err=1 sticky.
//  7 Assert reset with 2 reads outstanding -> outputs at reset values immediately, credits=4 after release.

Source files
------------

// File: rtl/axi_slave_arb_pkg.sv
// Shared types for the axi_slave memory arbiter: grant encoding and memory command struct.
package axi_slave_arb_pkg;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;
  localparam int ARB_SW = ARB_DW / 8;

  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} arb_gnt_t;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic [ARB_SW-1:0] wstrb;
  } arb_cmd_t;

  // Round-robin partner: after a write the read side is favoured and vice versa.
  function automatic arb_gnt_t other_side(arb_gnt_t g);
    return (g == GNT_WR) ? GNT_RD : GNT_WR;
  endfunction

endpackage

// File: rtl/axi_slave_arb_retq.sv
// In-order read-return queue: synchronous FIFO with occupancy count.
// Push and pop in the same cycle are accepted even when the queue is full.
module axi_slave_arb_retq
  import axi_slave_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axi_slave_mem_arb.sv
// Shares one single-ported memory command port between the axi_slave write and
// read packet channels: round-robin with grant lock, credit-limited reads and
// an in-order read-return queue.
// Optional build macro AXI_SLV_ARB_WR_BURST_EN: writes may win up to
// WR_BURST_MAX consecutive contested grants before yielding one to a read.
module axi_slave_mem_arb
  import axi_slave_arb_pkg::*;
#(
  parameter int  AW              = ARB_AW,
  parameter int  DW              = ARB_DW,
  parameter int  SW              = DW / 8,
  parameter int  MAX_OUTSTANDING = 4,
  parameter int  WR_BURST_MAX    = 4,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          i_axi_aclk,
  input  logic          i_axi_aresetn,
  input  logic          i_wr_pkt_valid,
  output logic          o_wr_pkt_ready,
  input  logic [AW-1:0] i_wr_pkt_addr,
  input  logic [DW-1:0] i_wr_pkt_data,
  input  logic [SW-1:0] i_wr_pkt_strb,
  input  logic          i_rd_pkt_valid,
  output logic          o_rd_pkt_ready,
  input  logic [AW-1:0] i_rd_pkt_addr,
  output logic          o_rdret_pkt_valid,
  input  logic          i_rdret_pkt_ready,
  output logic [DW-1:0] o_rdret_pkt_data,
  output logic          o_mem_valid,
  input  logic          i_mem_ready,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [SW-1:0] o_mem_wstrb,
  input  logic          i_mem_rvalid,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [CW-1:0] o_rd_outstanding,
  output logic          o_err
);

  localparam logic [CW-1:0] CREDITS_MAX = CW'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1 || WR_BURST_MAX < 1) begin : g_param_check
    $error("axi_slave_mem_arb: MAX_OUTSTANDING and WR_BURST_MAX must be >= 1");
  end

  arb_gnt_t      gnt;
  arb_gnt_t      last_gnt;
  arb_gnt_t      lock_gnt;
  logic          lock;
  arb_cmd_t      cmd;
  logic [CW-1:0] credits;
  logic          wr_elig;
  logic          rd_elig;
  logic          wr_first;
  logic          mem_hs;
  logic          wr_hs;
  logic          rd_hs;
  logic          ret_hs;
  logic          rvalid_bad;
  logic          retq_push;
  logic          retq_empty;
  logic [CW-1:0] retq_count;

  assign wr_elig = i_wr_pkt_valid;
  assign rd_elig = i_rd_pkt_valid && (credits != '0);

`ifdef AXI_SLV_ARB_WR_BURST_EN
  localparam int BW = $clog2(WR_BURST_MAX + 1);
  logic [BW-1:0] burst_cnt;

  assign wr_first = (last_gnt == GNT_RD) || (burst_cnt < BW'(WR_BURST_MAX));

  // Counts consecutive write handshakes; a read grant or an idle write side restarts the burst.
  always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      burst_cnt <= '0;
    end else if (!i_wr_pkt_valid || rd_hs) begin
      burst_cnt <= '0;
    end else if (wr_hs && (burst_cnt < BW'(WR_BURST_MAX))) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  assign wr_first = (other_side(last_gnt) == GNT_WR);
`endif

  // Grant selection; reset forces no grant so the command port is quiet while held in reset.
  always_comb begin
    gnt = GNT_NONE;
    if (!i_axi_aresetn) gnt = GNT_NONE;
    else if (lock) gnt = lock_gnt;
    else if (wr_elig && rd_elig) gnt = wr_first ? GNT_WR : GNT_RD;
    else if (wr_elig) gnt = GNT_WR;
    else if (rd_elig) gnt = GNT_RD;
  end

  // Steer the granted request onto the memory command port; reads carry zero data and strobes.
  always_comb begin
    cmd         = '0;
    o_mem_valid = 1'b0;
    case (gnt)
      GNT_WR: begin
        cmd.we      = 1'b1;
        cmd.addr    = i_wr_pkt_addr;
        cmd.wdata   = i_wr_pkt_data;
        cmd.wstrb   = i_wr_pkt_strb;
        o_mem_valid = i_wr_pkt_valid;
      end
      GNT_RD: begin
        cmd.addr    = i_rd_pkt_addr;
        o_mem_valid = i_rd_pkt_valid;
      end
      default: ;
    endcase
  end

  assign o_mem_we       = cmd.we;
  assign o_mem_addr     = cmd.addr;
  assign o_mem_wdata    = cmd.wdata;
  assign o_mem_wstrb    = cmd.wstrb;
  assign o_wr_pkt_ready = (gnt == GNT_WR) && i_mem_ready;
  assign o_rd_pkt_ready = (gnt == GNT_RD) && i_mem_ready;

  assign mem_hs = o_mem_valid && i_mem_ready;
  assign wr_hs  = mem_hs && (gnt == GNT_WR);
  assign rd_hs  = mem_hs && (gnt == GNT_RD);
  assign ret_hs = o_rdret_pkt_valid && i_rdret_pkt_ready;

  // Data returned with nothing outstanding, or into a full queue not draining this cycle, is dropped.
  assign rvalid_bad = i_mem_rvalid &&
                      ((credits == CREDITS_MAX) || ((retq_count == CREDITS_MAX) && !ret_hs));
  assign retq_push  = i_mem_rvalid && !rvalid_bad;

  // Grant lock holds a stalled command stable; last-grant advances on every accepted command.
  always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      lock     <= 1'b0;
      lock_gnt <= GNT_NONE;
      last_gnt <= GNT_RD;
    end else begin
      if (o_mem_valid && !i_mem_ready) begin
        lock     <= 1'b1;
        lock_gnt <= gnt;
      end else begin
        lock <= 1'b0;
      end
      if (mem_hs) last_gnt <= gnt;
    end
  end

  // Read credits: consumed when a read is issued, returned when its data is delivered.
  always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      credits <= CREDITS_MAX;
    end else begin
      case ({rd_hs, ret_hs})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) o_err <= 1'b0;
    else if (rvalid_bad) o_err <= 1'b1;
  end

  assign o_rd_outstanding  = CREDITS_MAX - credits;
  assign o_rdret_pkt_valid = !retq_empty;

  axi_slave_arb_retq #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (DW),
    .CW    (CW)
  ) u_retq (
    .clk   (i_axi_aclk),
    .rst_n (i_axi_aresetn),
    .push  (retq_push),
    .wdata (i_mem_rdata),
    .pop   (ret_hs),
    .rdata (o_rdret_pkt_data),
    .empty (retq_empty),
    .count (retq_count)
  );

endmodule

// File: tb/tb_axi_slave_mem_arb.sv
// Self-checking bench for axi_slave_mem_arb with randomized payloads and a
// queue-based reference model of issue order, credits and read returns.
// Honours AXI_SLV_ARB_WR_BURST_EN when predicting the contested grant pattern.
module tb_axi_slave_mem_arb;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int MAXO = 4;
  localparam int WBM  = 4;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wr_pkt_valid, o_wr_pkt_ready;
  logic [AW-1:0] i_wr_pkt_addr;
  logic [DW-1:0] i_wr_pkt_data;
  logic [SW-1:0] i_wr_pkt_strb;
  logic          i_rd_pkt_valid, o_rd_pkt_ready;
  logic [AW-1:0] i_rd_pkt_addr;
  logic          o_rdret_pkt_valid, i_rdret_pkt_ready;
  logic [DW-1:0] o_rdret_pkt_data;
  logic          o_mem_valid, i_mem_ready, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [SW-1:0] o_mem_wstrb;
  logic          i_mem_rvalid;
  logic [DW-1:0] i_mem_rdata;
  logic [CW-1:0] o_rd_outstanding;
  logic          o_err;

  always #5 clk = ~clk;

  axi_slave_mem_arb #(
    .AW(AW), .DW(DW), .SW(SW), .MAX_OUTSTANDING(MAXO), .WR_BURST_MAX(WBM)
  ) dut (
    .i_axi_aclk(clk), .i_axi_aresetn(rst_n),
    .i_wr_pkt_valid(i_wr_pkt_valid), .o_wr_pkt_ready(o_wr_pkt_ready),
    .i_wr_pkt_addr(i_wr_pkt_addr), .i_wr_pkt_data(i_wr_pkt_data), .i_wr_pkt_strb(i_wr_pkt_strb),
    .i_rd_pkt_valid(i_rd_pkt_valid), .o_rd_pkt_ready(o_rd_pkt_ready), .i_rd_pkt_addr(i_rd_pkt_addr),
    .o_rdret_pkt_valid(o_rdret_pkt_valid), .i_rdret_pkt_ready(i_rdret_pkt_ready),
    .o_rdret_pkt_data(o_rdret_pkt_data),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_rd_outstanding(o_rd_outstanding), .o_err(o_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            auto_ret;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] pend_q[$];
  int            issued, delivered, model_out;

  // Snapshot of DUT outputs taken mid-cycle before each clock edge
  byte           snap_gnt;
  logic          snap_valid, snap_we, snap_wr_ready, snap_rd_ready, snap_rdret_valid, snap_err;
  logic [AW-1:0] snap_addr;
  logic [DW-1:0] snap_wdata;
  logic [SW-1:0] snap_wstrb;
  logic [CW-1:0] snap_out;

  // One clock: sample outputs, update the model, advance, then play the memory return.
  task automatic step();
    #1;
    snap_valid       = o_mem_valid;
    snap_we          = o_mem_we;
    snap_addr        = o_mem_addr;
    snap_wdata       = o_mem_wdata;
    snap_wstrb       = o_mem_wstrb;
    snap_wr_ready    = o_wr_pkt_ready;
    snap_rd_ready    = o_rd_pkt_ready;
    snap_rdret_valid = o_rdret_pkt_valid;
    snap_err         = o_err;
    snap_out         = o_rd_outstanding;
    snap_gnt         = !o_mem_valid ? "-" : (o_mem_we ? "W" : "R");
    model_out        = issued - delivered;
    if (o_mem_valid && i_mem_ready && !o_mem_we) begin
      issued++;
      if (auto_ret) pend_q.push_back($urandom);
    end
    if (o_rdret_pkt_valid && i_rdret_pkt_ready) begin
      delivered++;
      got_q.push_back(o_rdret_pkt_data);
    end
    @(posedge clk);
    #1;
    i_mem_rvalid = 1'b0;
    if (auto_ret && pend_q.size() > 0) begin
      i_mem_rdata  = pend_q.pop_front();
      i_mem_rvalid = 1'b1;
      exp_q.push_back(i_mem_rdata);
    end
  endtask

  task automatic idle_inputs();
    i_wr_pkt_valid = 0; i_wr_pkt_addr = '0; i_wr_pkt_data = '0; i_wr_pkt_strb = '0;
    i_rd_pkt_valid = 0; i_rd_pkt_addr = '0; i_rdret_pkt_ready = 0;
    i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
  endtask

  task automatic clear_model();
    auto_ret = 0; issued = 0; delivered = 0; model_out = 0;
    exp_q.delete(); got_q.delete(); pend_q.delete();
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    clear_model();
    i_wr_pkt_valid = 1; i_rd_pkt_valid = 1; i_mem_ready = 1; i_rdret_pkt_ready = 1;
    @(posedge clk); #2;
    total++; if (o_mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", o_mem_valid); end
    total++; if (o_wr_pkt_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b exp=0", o_wr_pkt_ready); end
    total++; if (o_rd_pkt_ready !== 1'b0) begin bad++; $display("FAIL reset_rd_ready got=%b exp=0", o_rd_pkt_ready); end
    total++; if (o_rdret_pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_rdret_valid got=%b exp=0", o_rdret_pkt_valid); end
    total++; if (o_rd_outstanding !== '0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", o_rd_outstanding); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_err); end
    idle_inputs();
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_writes_only();
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    i_mem_ready = 1;
    i_wr_pkt_valid = 1;
    for (int i = 0; i < 3; i++) begin
      d = $urandom; s = SW'($urandom);
      i_wr_pkt_addr = 32'h100 + 32'(4 * i); i_wr_pkt_data = d; i_wr_pkt_strb = s;
      step();
      total++; if (snap_gnt !== "W") begin bad++; $display("FAIL wr_only_grant[%0d] got=%c exp=W", i, snap_gnt); end
      total++; if (snap_wr_ready !== 1'b1) begin bad++; $display("FAIL wr_only_ready[%0d] got=%b exp=1", i, snap_wr_ready); end
      total++; if (snap_addr !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL wr_only_addr[%0d] got=%h exp=%h", i, snap_addr, 32'h100 + 32'(4 * i)); end
      total++; if (snap_wdata !== d) begin bad++; $display("FAIL wr_only_wdata[%0d] got=%h exp=%h", i, snap_wdata, d); end
      total++; if (snap_wstrb !== s) begin bad++; $display("FAIL wr_only_wstrb[%0d] got=%h exp=%h", i, snap_wstrb, s); end
    end
    i_wr_pkt_valid = 0;
  endtask

  task automatic test_alternation();
    byte           exp_g;
    int            reads;
    logic [AW-1:0] wa, ra;
    apply_reset();
    auto_ret = 1; i_mem_ready = 1; i_rdret_pkt_ready = 1;
    wa = $urandom; ra = $urandom; reads = 0;
    i_wr_pkt_valid = 1; i_rd_pkt_valid = 1;
    for (int k = 0; k < 10; k++) begin
      i_wr_pkt_addr = wa; i_rd_pkt_addr = ra; i_wr_pkt_data = $urandom;
`ifdef AXI_SLV_ARB_WR_BURST_EN
      exp_g = (k % (WBM + 1) < WBM) ? "W" : "R";
`else
      exp_g = (k % 2 == 0) ? "W" : "R";
`endif
      if (exp_g == "R") reads++;
      step();
      total++; if (snap_gnt !== exp_g) begin bad++; $display("FAIL alt_grant[%0d] got=%c exp=%c", k, snap_gnt, exp_g); end
      total++; if (snap_addr !== ((exp_g == "W") ? wa : ra)) begin bad++; $display("FAIL alt_addr[%0d] got=%h exp=%h", k, snap_addr, (exp_g == "W") ? wa : ra); end
      if (snap_wr_ready) wa = $urandom;
      if (snap_rd_ready) ra = $urandom;
    end
    i_wr_pkt_valid = 0; i_rd_pkt_valid = 0;
    repeat (4) step();
    total++; if (got_q.size() !== reads) begin bad++; $display("FAIL alt_returns got=%0d exp=%0d", got_q.size(), reads); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL alt_ret_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_credit_limit();
    apply_reset();
    i_mem_ready = 1; i_rd_pkt_valid = 1;
    for (int i = 0; i < 6; i++) begin
      i_rd_pkt_addr = $urandom;
      step();
      total++; if (snap_rd_ready !== ((i < MAXO) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL credit_rd_ready[%0d] got=%b exp=%b", i, snap_rd_ready, (i < MAXO)); end
    end
    total++; if (snap_out !== CW'(MAXO)) begin bad++; $display("FAIL credit_outstanding got=%0d exp=%0d", snap_out, MAXO); end
    i_wr_pkt_valid = 1; i_wr_pkt_addr = $urandom;
    step();
    total++; if (snap_wr_ready !== 1'b1 || snap_gnt !== "W") begin bad++; $display("FAIL credit_write_granted got=%c/%b exp=W/1", snap_gnt, snap_wr_ready); end
    i_wr_pkt_valid = 0; i_rd_pkt_valid = 0;
  endtask

  // Continues from test_credit_limit with all four reads outstanding.
  task automatic test_return_queue();
    logic [DW-1:0] d;
    logic          both_rd, both_ret;
    for (int i = 0; i < MAXO; i++) begin
      i_mem_rvalid = 1; i_mem_rdata = 32'hA0 + 32'(i); exp_q.push_back(i_mem_rdata);
      step();
    end
    step();
    total++; if (snap_err !== 1'b0) begin bad++; $display("FAIL retq_err got=%b exp=0", snap_err); end
    total++; if (snap_rdret_valid !== 1'b1) begin bad++; $display("FAIL retq_valid got=%b exp=1", snap_rdret_valid); end
    total++; if (snap_out !== CW'(MAXO)) begin bad++; $display("FAIL retq_held_out got=%0d exp=%0d", snap_out, MAXO); end
    i_rdret_pkt_ready = 1;
    repeat (MAXO + 1) step();
    total++; if (got_q.size() !== MAXO) begin bad++; $display("FAIL retq_count got=%0d exp=%0d", got_q.size(), MAXO); end
    for (int i = 0; i < got_q.size() && i < MAXO; i++) begin
      total++; if (got_q[i] !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL retq_order[%0d] got=%h exp=%h", i, got_q[i], 32'hA0 + 32'(i)); end
    end
    total++; if (snap_out !== '0) begin bad++; $display("FAIL retq_credits_back got=%0d exp=0", snap_out); end
    i_rd_pkt_valid = 1; i_rd_pkt_addr = $urandom;
    step();
    i_rd_pkt_valid = 0;
    d = $urandom; i_mem_rvalid = 1; i_mem_rdata = d; exp_q.push_back(d);
    step();
    i_rd_pkt_valid = 1; i_rd_pkt_addr = $urandom;
    step();
    both_rd = snap_rd_ready; both_ret = snap_rdret_valid;
    i_rd_pkt_valid = 0;
    step();
    total++; if ({both_rd, both_ret} !== 2'b11) begin bad++; $display("FAIL same_cycle_handshakes got=%b%b exp=11", both_rd, both_ret); end
    total++; if (snap_out !== CW'(1)) begin bad++; $display("FAIL same_cycle_outstanding got=%0d exp=1", snap_out); end
    total++; if (got_q[got_q.size()-1] !== d) begin bad++; $display("FAIL same_cycle_data got=%h exp=%h", got_q[got_q.size()-1], d); end
  endtask

  task automatic test_lock();
    logic [AW-1:0] ra, wa;
    apply_reset();
    ra = $urandom; wa = $urandom;
    i_rd_pkt_valid = 1; i_rd_pkt_addr = ra; i_mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (snap_gnt !== "R" || snap_addr !== ra) begin bad++; $display("FAIL lock_hold[%0d] got=%c/%h exp=R/%h", i, snap_gnt, snap_addr, ra); end
      total++; if ({snap_rd_ready, snap_wr_ready} !== 2'b00) begin bad++; $display("FAIL lock_ready[%0d] got=%b%b exp=00", i, snap_rd_ready, snap_wr_ready); end
      i_wr_pkt_valid = 1; i_wr_pkt_addr = wa;
    end
    i_mem_ready = 1;
    step();
    total++; if (snap_gnt !== "R" || snap_rd_ready !== 1'b1) begin bad++; $display("FAIL lock_release got=%c/%b exp=R/1", snap_gnt, snap_rd_ready); end
    i_rd_pkt_valid = 0;
    step();
    total++; if (snap_gnt !== "W" || snap_addr !== wa || snap_wr_ready !== 1'b1) begin bad++; $display("FAIL lock_next_write got=%c/%h/%b exp=W/%h/1", snap_gnt, snap_addr, snap_wr_ready, wa); end
    i_wr_pkt_valid = 0;
  endtask

  task automatic test_err();
    int n;
    apply_reset();
    i_mem_rvalid = 1; i_mem_rdata = $urandom;
    step();
    step();
    total++; if (snap_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", snap_err); end
    total++; if (snap_rdret_valid !== 1'b0) begin bad++; $display("FAIL err_dropped got=%b exp=0", snap_rdret_valid); end
    n = $urandom_range(3, 8);
    repeat (n) step();
    total++; if (snap_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", snap_err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_mem_ready = 1; i_rd_pkt_valid = 1;
    repeat (2) begin i_rd_pkt_addr = $urandom; step(); end
    i_rd_pkt_valid = 0;
    i_mem_rvalid = 1; i_mem_rdata = $urandom;
    step();
    i_wr_pkt_valid = 1; i_wr_pkt_addr = $urandom;
    #2;
    total++; if (o_mem_valid !== 1'b1 || o_rdret_pkt_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%b%b exp=11", o_mem_valid, o_rdret_pkt_valid); end
    rst_n = 0;
    #1;
    total++; if (o_mem_valid !== 1'b0 || o_wr_pkt_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_cmd got=%b%b exp=00", o_mem_valid, o_wr_pkt_ready); end
    total++; if (o_rd_outstanding !== '0 || o_rdret_pkt_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_state got=%0d/%b exp=0/0", o_rd_outstanding, o_rdret_pkt_valid); end
    idle_inputs();
    clear_model();
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    i_mem_ready = 1; i_rd_pkt_valid = 1;
    for (int i = 0; i < MAXO; i++) begin
      i_rd_pkt_addr = $urandom;
      step();
      total++; if (snap_rd_ready !== 1'b1) begin bad++; $display("FAIL post_reset_credit[%0d] got=%b exp=1", i, snap_rd_ready); end
    end
    step();
    total++; if (snap_rd_ready !== 1'b0 || snap_out !== CW'(MAXO)) begin bad++; $display("FAIL post_reset_limit got=%b/%0d exp=0/%0d", snap_rd_ready, snap_out, MAXO); end
    i_rd_pkt_valid = 0;
  endtask

  task automatic test_random();
    logic          prev_stall, prev_we;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    apply_reset();
    auto_ret = 1; prev_stall = 0; prev_we = 0; prev_addr = '0; prev_wdata = '0;
    for (int c = 0; c < 300; c++) begin
      if (!i_wr_pkt_valid && $urandom_range(0, 1) == 1) begin
        i_wr_pkt_valid = 1; i_wr_pkt_addr = $urandom; i_wr_pkt_data = $urandom; i_wr_pkt_strb = SW'($urandom);
      end
      if (!i_rd_pkt_valid && $urandom_range(0, 1) == 1) begin
        i_rd_pkt_valid = 1; i_rd_pkt_addr = $urandom;
      end
      i_mem_ready = ($urandom_range(0, 3) != 0);
      i_rdret_pkt_ready = ($urandom_range(0, 3) != 0);
      step();
      total++; if (snap_out !== CW'(model_out)) begin bad++; $display("FAIL rnd_outstanding[%0d] got=%0d exp=%0d", c, snap_out, model_out); end
      if (model_out == MAXO) begin
        total++; if (snap_rd_ready !== 1'b0) begin bad++; $display("FAIL rnd_no_credit[%0d] got=%b exp=0", c, snap_rd_ready); end
      end
      if (prev_stall) begin
        total++; if (snap_valid !== 1'b1 || snap_we !== prev_we || snap_addr !== prev_addr || snap_wdata !== prev_wdata) begin
          bad++; $display("FAIL rnd_stable[%0d] got=%b/%b/%h/%h exp=1/%b/%h/%h", c, snap_valid, snap_we, snap_addr, snap_wdata, prev_we, prev_addr, prev_wdata);
        end
      end
      prev_stall = snap_valid && !i_mem_ready;
      prev_we = snap_we; prev_addr = snap_addr; prev_wdata = snap_wdata;
      if (snap_wr_ready) i_wr_pkt_valid = 0;
      if (snap_rd_ready) i_rd_pkt_valid = 0;
    end
    i_wr_pkt_valid = 0; i_rd_pkt_valid = 0; i_mem_ready = 1; i_rdret_pkt_ready = 1;
    repeat (8) step();
    total++; if (got_q.size() !== exp_q.size() || delivered !== issued) begin bad++; $display("FAIL rnd_drain got=%0d/%0d exp=%0d/%0d", got_q.size(), delivered, exp_q.size(), issued); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_ret_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (snap_err !== 1'b0) begin bad++; $display("FAIL rnd_err got=%b exp=0", snap_err); end
  endtask

  initial begin
    $display("[TB] axi_slave_mem_arb bench start");
    test_reset();
    test_writes_only();
    test_alternation();
    test_credit_limit();
    test_return_queue();
    test_lock();
    test_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
